// File: rtl/dot_pkg.sv
// dot_pkg: shared widths and sequencer state type for the integer dot-product blocks
package dot_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dot_seq_state_t;

    function automatic int out_width(input int bw, input int k);
        return 2 * bw + $clog2(k);
    endfunction

    function automatic int acc_width(input int bw, input int k, input int mb);
        return out_width(bw, k) + $clog2(mb);
    endfunction

endpackage

// File: rtl/dot_int.sv
// dot_int: combinational k-lane signed integer dot product, exact width
module dot_int
    import dot_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int k         = 32
) (
    input  logic signed [bit_width-1:0]                  i_vec_a [k],
    input  logic signed [bit_width-1:0]                  i_vec_b [k],
    output logic signed [out_width(bit_width, k)-1:0]    o_dp
);

    logic signed [2*bit_width-1:0] w_prod;

    // sum of lane products; the output width leaves $clog2(k) guard bits so it never overflows
    always_comb begin
        o_dp   = '0;
        w_prod = '0;
        for (int j = 0; j < k; j++) begin
            w_prod = i_vec_a[j] * i_vec_b[j];
            o_dp   = o_dp + w_prod;
        end
    end

endmodule

// File: rtl/dot_int_seq.sv
// dot_int_seq: streams up to max_blocks k-lane beats per job through dot_int and accumulates them exactly
module dot_int_seq
    import dot_pkg::*;
#(
    parameter int bit_width  = 8,
    parameter int k          = 32,
    parameter int max_blocks = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                i_valid,
    output logic                                                o_ready,
    input  logic signed [bit_width-1:0]                         i_vec_a [k],
    input  logic signed [bit_width-1:0]                         i_vec_b [k],
    input  logic [$clog2(max_blocks)-1:0]                       i_len,
    output logic                                                o_valid,
    input  logic                                                i_ready,
    output logic signed [acc_width(bit_width, k, max_blocks)-1:0] o_acc
);

    localparam int ow = out_width(bit_width, k);
    localparam int aw = acc_width(bit_width, k, max_blocks);
    localparam int lw = $clog2(max_blocks);

    dot_seq_state_t        r_state;
    logic [lw-1:0]         r_len;
    logic [lw-1:0]         r_cnt;
    logic signed [ow-1:0]  w_dp;
    logic signed [ow-1:0]  r_p0_dp;
    logic                  r_p0_vld;
    logic                  r_p0_first;
    logic signed [aw-1:0]  r_acc;
    logic                  w_beat;
    logic                  w_first;
    logic                  w_last;

    // handshake outputs come from state alone, so no input reaches them combinationally
    assign o_ready = (r_state == IDLE) || (r_state == RUN);
    assign o_valid = r_state == DONE;
    assign o_acc   = r_acc;
    assign w_beat  = i_valid && o_ready;
    assign w_first = r_state == IDLE;
    assign w_last  = w_first ? (i_len == '0) : (r_cnt == r_len);

    dot_int #(
        .bit_width (bit_width),
        .k         (k)
    ) u_dot (
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .o_dp    (w_dp)
    );

    // job sequencing: count accepted beats, then one drain cycle lets the accumulator catch up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_beat) begin
                    r_len   <= i_len;
                    r_cnt   <= lw'(1);
                    r_state <= w_last ? DRAIN : RUN;
                end
                RUN: if (w_beat) begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? DRAIN : RUN;
                end
                DRAIN: r_state <= DONE;
                DONE: r_state <= i_ready ? IDLE : DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // p0 stage: register each beat's partial product and whether it opens a new job
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_dp    <= '0;
            r_p0_vld   <= 1'b0;
            r_p0_first <= 1'b0;
        end else begin
            r_p0_dp    <= w_beat ? w_dp : r_p0_dp;
            r_p0_vld   <= w_beat;
            r_p0_first <= w_beat && w_first;
        end
    end

    // accumulate partials; the first partial of a job replaces the previous result
    always_ff @(posedge clk) begin
        if (rst) r_acc <= '0;
        else if (r_p0_vld) r_acc <= (r_p0_first ? '0 : r_acc) + aw'(r_p0_dp);
    end

endmodule

// File: tb/tb_dot_int_seq.sv
// tb_dot_int_seq: directed and randomized checks of dot_int_seq against a plain-arithmetic job-sum model
module tb_dot_int_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic               o_ready;
    logic signed [7:0]  i_vec_a [32];
    logic signed [7:0]  i_vec_b [32];
    logic [3:0]         i_len;
    logic               o_valid;
    logic               i_ready;
    logic signed [24:0] o_acc;

    logic signed [7:0]  tb_a [32];
    logic signed [7:0]  tb_b [32];
    longint             expd;
    int                 total = 0;
    int                 bad = 0;
    int                 n;
    int                 len;

    dot_int_seq #(.bit_width(8), .k(32), .max_blocks(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .i_len   (i_len),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_acc   (o_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input bit rnd, input int av, input int bv);
        foreach (tb_a[j]) begin
            tb_a[j] = rnd ? 8'($urandom) : 8'(av);
            tb_b[j] = rnd ? 8'($urandom) : 8'(bv);
        end
    endtask

    // gaps carry junk operands with i_valid low; the model only adds accepted beats
    task automatic beat(input int gaps, input logic [3:0] len_in);
        longint s = 0;
        repeat (gaps) begin
            i_valid = 1'b0;
            i_len   = 4'($urandom);
            foreach (i_vec_a[j]) begin
                i_vec_a[j] = 8'($urandom);
                i_vec_b[j] = 8'($urandom);
            end
            tick();
        end
        i_vec_a = tb_a;
        i_vec_b = tb_b;
        i_len   = len_in;
        i_valid = 1'b1;
        chk("beat_ready", o_ready, 1);
        tick();
        i_valid = 1'b0;
        foreach (tb_a[j]) s += longint'(tb_a[j]) * longint'(tb_b[j]);
        expd += s;
    endtask

    task automatic get_result(input int hold, input string tag, output int cyc);
        cyc = 0;
        i_ready = 1'b0;
        while (o_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_timeout"}, cyc < 100, 1);
        chk({tag, "_acc"}, o_acc, expd);
        repeat (hold) begin
            tick();
            chk({tag, "_hold_acc"}, o_acc, expd);
            chk({tag, "_hold_valid"}, o_valid, 1);
            chk({tag, "_hold_ready"}, o_ready, 0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_valid_drop"}, o_valid, 0);
        chk({tag, "_ready_rise"}, o_ready, 1);
        expd = 0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_len   = '0;
        expd    = 0;
        foreach (i_vec_a[j]) begin
            i_vec_a[j] = '0;
            i_vec_b[j] = '0;
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_acc", o_acc, 0);

        set_ops(0, 1, 2);
        beat(0, 4'd0);
        chk("drain_ready", o_ready, 0);
        chk("drain_valid", o_valid, 0);
        get_result(5, "single", n);
        chk("single_latency", n, 1);
        chk("single_value", 64, expd + 64);

        set_ops(0, -128, -128);
        for (int bt = 0; bt < 16; bt++) beat(0, bt == 0 ? 4'd15 : 4'd0);
        chk("max_pos_model", expd, 8388608);
        get_result(1, "max_pos", n);
        set_ops(0, -128, 127);
        for (int bt = 0; bt < 16; bt++) beat(0, bt == 0 ? 4'd15 : 4'($urandom));
        chk("max_neg_model", expd, -8323072);
        get_result(0, "max_neg", n);

        for (int bt = 0; bt < 4; bt++) begin
            set_ops(1, 0, 0);
            beat($urandom_range(0, 3), bt == 0 ? 4'd3 : 4'($urandom));
        end
        get_result(2, "gaps", n);

        set_ops(1, 0, 0);
        beat(0, 4'd1);
        beat(0, 4'd7);
        get_result(0, "b2b_first", n);
        set_ops(1, 0, 0);
        beat(0, 4'd2);
        beat(0, 4'd0);
        beat(0, 4'd9);
        get_result(0, "b2b_second", n);

        set_ops(1, 0, 0);
        beat(0, 4'd3);
        beat(1, 4'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expd = 0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_acc", o_acc, 0);
        set_ops(0, 3, 3);
        beat(0, 4'd0);
        chk("midrst_model", expd, 288);
        get_result(0, "midrst_fresh", n);

        for (int j = 0; j < 300; j++) begin
            len = $urandom_range(0, 15);
            for (int bt = 0; bt <= len; bt++) begin
                set_ops(1, 0, 0);
                beat($urandom_range(0, 2), bt == 0 ? 4'(len) : 4'($urandom));
            end
            get_result($urandom_range(0, 3), "rand", n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
